// File: rtl/button_interface.sv
// Bus-mapped push-button peripheral: two-flop synchronisers, per-button debounce
// FSMs, sticky write-1-to-clear press flags and a level pending output.
module button_interface #(
    parameter int NBTN            = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic            write,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [NBTN-1:0] buttons,
    output logic            pending
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    logic [NBTN-1:0] sync1_q, sync1_d;
    logic [NBTN-1:0] sync2_q, sync2_d;
    logic [NBTN-1:0] press_q, press_d;
    logic            pending_q, pending_d;
    state_t          state_q [NBTN];
    state_t          state_d [NBTN];
    logic [CW-1:0]   cnt_q   [NBTN];
    logic [CW-1:0]   cnt_d   [NBTN];

    logic [NBTN-1:0] accept_rise;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] busy;
    logic [NBTN-1:0] clr_mask;

    // Only the low NBTN write-data bits carry clear requests.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:NBTN];

    always_comb begin
        sync1_d     = buttons;
        sync2_d     = sync1_q;
        accept_rise = '0;
        stable      = '0;
        busy        = '0;
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_RISE;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ST_RISE: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]     = ST_HIGH;
                        cnt_d[i]       = '0;
                        accept_rise[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_FALL;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ST_FALL: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
            stable[i] = (state_q[i] == ST_HIGH) || (state_q[i] == ST_FALL);
            busy[i]   = (state_q[i] == ST_RISE) || (state_q[i] == ST_FALL);
        end
    end

    // An accepted press applied after the clear lets a same-cycle set win.
    always_comb begin
        clr_mask  = write ? wdata[NBTN-1:0] : '0;
        press_d   = (press_q & ~clr_mask) | accept_rise;
        pending_d = |press_d;
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            press_q   <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            press_q   <= press_d;
            pending_q <= pending_d;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        rdata              = '0;
        rdata[NBTN-1:0]    = press_q;
        rdata[8 +: NBTN]   = stable;
        rdata[16 +: NBTN]  = busy;
    end

    assign pending = pending_q;

endmodule

// File: tb/tb_button_interface.sv
// Self-checking bench for button_interface: directed scenarios plus randomized
// traffic compared against a run-length debounce model.
module tb_button_interface;

    localparam int NB = 4;
    localparam int DC = 4;

    logic        clock;
    logic        nreset;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [NB-1:0] buttons;
    logic        pending;

    int n_cmp;
    int n_bad;

    // Reference state: delayed pin copies, accepted levels, sticky flags and
    // the length of the current run where the synchronised level differs.
    logic [NB-1:0] m_s1, m_s2, m_stable, m_press;
    int            m_run [NB];

    button_interface #(
        .NBTN(NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock(clock),
        .nreset(nreset),
        .write(write),
        .wdata(wdata),
        .rdata(rdata),
        .buttons(buttons),
        .pending(pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[i]      = m_press[i];
            r[8 + i]  = m_stable[i];
            r[16 + i] = (m_run[i] != 0);
        end
        return r;
    endfunction

    // Advance the model across the coming edge, then wait for it and settle.
    task automatic tick();
        logic [NB-1:0] clr;
        if (!nreset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
        end else begin
            clr = write ? wdata[NB-1:0] : '0;
            m_press = m_press & ~clr;
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DC) begin
                        m_stable[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_s2[i]) m_press[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = buttons;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0; write = 1'b0; wdata = '0; buttons = '0;
        tick();
        tick();
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; write = 1'b0; wdata = '0; buttons = 4'hF;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (rdata !== 32'h0 || pending !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: rdata=%h pending=%b want 0/0", rdata, pending);
            end
        end
        nreset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) begin
                n_cmp++;
                if (rdata[11:8] !== 4'h0) begin
                    n_bad++;
                    $display("FAIL reset_early_stable: stable=%h want 0", rdata[11:8]);
                end
            end
        end
        n_cmp++;
        if (rdata !== 32'h0000_0F0F || pending !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_held_release: rdata=%h pending=%b want 00000f0f/1", rdata, pending);
        end
    endtask

    task automatic test_clean_press();
        logic want_busy;
        do_reset();
        buttons = 4'h1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            want_busy = (k >= 3 && k <= 5);
            n_cmp++;
            if (rdata[16] !== want_busy) begin
                n_bad++;
                $display("FAIL press_busy edge %0d: got %b want %b", k, rdata[16], want_busy);
            end
        end
        n_cmp++;
        if (rdata !== 32'h0000_0101 || pending !== 1'b1) begin
            n_bad++;
            $display("FAIL press_accept: rdata=%h pending=%b want 00000101/1", rdata, pending);
        end
        for (int k = 0; k < 10; k++) tick();
        buttons = 4'h0;
        for (int k = 0; k < 6; k++) tick();
        n_cmp++;
        if (rdata !== 32'h0000_0001 || pending !== 1'b1) begin
            n_bad++;
            $display("FAIL press_release: rdata=%h pending=%b want 00000001/1", rdata, pending);
        end
    endtask

    task automatic test_glitch();
        logic want_busy;
        do_reset();
        buttons = 4'h2;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) buttons = 4'h0;
            tick();
            want_busy = (k >= 3 && k <= 5);
            n_cmp++;
            if (rdata[17] !== want_busy || rdata[9] !== 1'b0 || rdata[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch edge %0d: rdata=%h want busy1=%b stable1=0 press1=0",
                         k, rdata, want_busy);
            end
        end
    endtask

    task automatic test_w1c();
        do_reset();
        buttons = 4'b0101;
        for (int k = 0; k < 6; k++) tick();
        n_cmp++;
        if (rdata[3:0] !== 4'b0101) begin
            n_bad++;
            $display("FAIL w1c_setup: press=%b want 0101", rdata[3:0]);
        end
        write = 1'b1; wdata = 32'hFFFF_FFF4;
        tick();
        write = 1'b0; wdata = '0;
        n_cmp++;
        if (rdata[3:0] !== 4'b0001 || pending !== 1'b1 || rdata[11:8] !== 4'b0101) begin
            n_bad++;
            $display("FAIL w1c_partial: rdata=%h pending=%b want press 0001 stable 0101 pend 1",
                     rdata, pending);
        end
        write = 1'b1; wdata = 32'h1;
        tick();
        write = 1'b0; wdata = '0;
        n_cmp++;
        if (rdata[3:0] !== 4'b0000 || pending !== 1'b0) begin
            n_bad++;
            $display("FAIL w1c_all: press=%b pending=%b want 0000/0", rdata[3:0], pending);
        end
    endtask

    task automatic test_collision();
        do_reset();
        buttons = 4'h4;
        for (int k = 0; k < 5; k++) tick();
        write = 1'b1; wdata = 32'h4;
        tick();
        write = 1'b0; wdata = '0;
        n_cmp++;
        if (rdata[2] !== 1'b1 || pending !== 1'b1) begin
            n_bad++;
            $display("FAIL collision: press2=%b pending=%b want 1/1", rdata[2], pending);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        buttons = 4'h8;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (rdata[19] !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_busy: busy3=%b want 1", rdata[19]);
        end
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset_clear: rdata=%h want 0", rdata);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) begin
                n_cmp++;
                if (rdata[3] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midreset_early: press3=%b want 0", rdata[3]);
                end
            end
        end
        n_cmp++;
        if (rdata[3] !== 1'b1 || pending !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_accept: press3=%b pending=%b want 1/1", rdata[3], pending);
        end
    endtask

    task automatic test_random();
        int hold [NB];
        logic [31:0] exp_r;
        do_reset();
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    buttons[i] = $urandom_range(0, 1);
                    hold[i] = $urandom_range(1, 8);
                end else begin
                    hold[i] = hold[i] - 1;
                end
            end
            write  = ($urandom_range(0, 7) == 0);
            wdata  = $urandom;
            nreset = ($urandom_range(0, 199) != 0);
            tick();
            exp_r = model_rdata();
            n_cmp++;
            if (rdata !== exp_r || pending !== (|m_press)) begin
                n_bad++;
                $display("FAIL random cyc %0d: rdata=%h pending=%b want %h/%b",
                         cyc, rdata, pending, exp_r, |m_press);
            end
        end
        nreset = 1'b1; write = 1'b0; wdata = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nreset = 1'b0; write = 1'b0; wdata = '0; buttons = '0;
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_w1c();
        test_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
